// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four valid/ready requesters at a time
// for bursts of up to MAX_BURST beats into a registered valid/ready output stage.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic             grant_active
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [1:0]     grant_idx, grant_idx_nxt;
    logic [1:0]     winner;
    logic [BW-1:0]  beat_cnt, beat_cnt_nxt;
    logic           can_load;
    logic           transfer;
    logic           last_beat;
    logic [WIDTH-1:0] sel_data;

    assign grant_active = (state == GRANT);
    assign can_load     = !out_valid || out_ready;
    assign transfer     = grant_active && req_valid[grant_idx] && can_load;
    assign last_beat    = (beat_cnt == BW'(MAX_BURST - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        req_ready = 4'b0000;
        if (grant_active)
            req_ready[grant_idx] = can_load;
    end

    always_comb begin
        case (grant_idx)
            2'd0:    sel_data = req_data0;
            2'd1:    sel_data = req_data1;
            2'd2:    sel_data = req_data2;
            default: sel_data = req_data3;
        endcase
    end

    // Descending scan so the requester closest to ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr + 2'(k)])
                winner = ptr + 2'(k);
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_idx_nxt = grant_idx;
        beat_cnt_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_idx_nxt = winner;
                    beat_cnt_nxt  = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (transfer) begin
                    if (last_beat) begin
                        state_nxt    = IDLE;
                        ptr_nxt      = grant_idx + 2'd1;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BW'(1);
                    end
                end else if (can_load) begin
                    // Requester went quiet while the output could accept: release early.
                    state_nxt    = IDLE;
                    ptr_nxt      = grant_idx + 2'd1;
                    beat_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            grant_idx <= 2'd0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= grant_idx_nxt;
            beat_cnt  <= beat_cnt_nxt;
        end
    end

    // Output register: loads on transfer, drains when consumed, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
        end else if (can_load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a rule-level model of the round-robin burst arbiter.
module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = 4'b0000;
    logic [WIDTH-1:0] d [4];
    logic             out_ready = 1'b1;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             grant_active;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data0    (d[0]),
        .req_data1    (d[1]),
        .req_data2    (d[2]),
        .req_data3    (d[3]),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the path, how many beats delivered, where the search
    // restarts, and the beat currently presented downstream.
    bit               m_busy;
    int               m_idx, m_beats, m_ptr, m_os;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               cl, xfer;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_idx = 0; m_beats = 0; m_ptr = 0;
            m_ov = 0; m_od = '0; m_os = 0;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out_data", 32'(out_data), 0);
            check("rst_out_src", 32'(out_src), 0);
            check("rst_grant_active", 32'(grant_active), 0);
            check("rst_req_ready", 32'(req_ready), 0);
        end else begin
            cl = !m_ov || out_ready;
            check("grant_active", 32'(grant_active), 32'(m_busy));
            check("req_ready", 32'(req_ready), (m_busy && cl) ? (32'd1 << m_idx) : 32'd0);
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("out_data", 32'(out_data), 32'(m_od));
            check("out_src", 32'(out_src), 32'(m_os));

            xfer = m_busy && req_valid[m_idx] && cl;
            if (xfer) begin
                m_ov = 1; m_od = d[m_idx]; m_os = m_idx;
            end else if (cl) begin
                m_ov = 0;
            end

            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_busy && req_valid[(m_ptr + k) % 4]) begin
                        m_busy  = 1;
                        m_idx   = (m_ptr + k) % 4;
                        m_beats = 0;
                    end
                end
            end else if (xfer) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_busy = 0; m_ptr = (m_idx + 1) % 4; m_beats = 0;
                end
            end else if (cl) begin
                m_busy = 0; m_ptr = (m_idx + 1) % 4; m_beats = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!grant_active && n < 30) begin
            step();
            #1;
            n++;
        end
        check({name, "_grant_seen"}, 32'(grant_active), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (grant_active && n < 30) begin
            step();
            #1;
            n++;
        end
        check({name, "_idle_seen"}, 32'(grant_active), 0);
    endtask

    initial begin
        int srcs[$];
        int gaps;
        bit started;

        for (int i = 0; i < 4; i++) d[i] = '0;

        // Single requester, two beats then valid drops.
        apply_reset();
        step();
        req_valid = 4'b0001; d[0] = 4'hA;
        #1; check("t1_idle_ready", 32'(req_ready), 0);
        step(); #1;
        check("t1_grant", 32'(grant_active), 1);
        check("t1_ready", 32'(req_ready), 32'b0001);
        check("t1_no_out_yet", 32'(out_valid), 0);
        step(); d[0] = 4'hB; #1;
        check("t1_first_valid", 32'(out_valid), 1);
        check("t1_beat_a", 32'(out_data), 32'hA);
        check("t1_src_a", 32'(out_src), 0);
        step(); req_valid = 4'b0000; #1;
        check("t1_beat_b", 32'(out_data), 32'hB);
        step(); #1;
        check("t1_released", 32'(grant_active), 0);
        check("t1_out_drained", 32'(out_valid), 0);
        check("t1_model_ptr", 32'(m_ptr), 1);

        // All four requesters continuously valid: bursts of four, one bubble apart.
        apply_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 4);
        req_valid = 4'b1111;
        gaps = 0; started = 0;
        for (int n = 0; n < 40 && srcs.size() < 17; n++) begin
            step(); #1;
            if (out_valid) begin
                srcs.push_back(int'(out_src));
                started = 1;
            end else if (started) begin
                gaps++;
            end
        end
        check("t2_beat_count", 32'(srcs.size()), 17);
        for (int k = 0; k < srcs.size(); k++)
            check("t2_src_seq", 32'(srcs[k]), 32'((k / 4) % 4));
        check("t2_bubbles", 32'(gaps), 4);

        // Backpressure mid-burst.
        wait_grant("t3");
        step();
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step(); #1;
            check("t3_stall_ready", 32'(req_ready), 0);
            check("t3_stall_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) step();

        // Pointer fairness after requester 2's grant.
        apply_reset();
        req_valid = 4'b0100;
        wait_grant("t4a");
        check("t4_first", 32'(req_ready), 32'b0100);
        req_valid = 4'b1010;
        wait_idle("t4a");
        wait_grant("t4b");
        check("t4_second", 32'(req_ready), 32'b1000);
        wait_idle("t4b");
        wait_grant("t4c");
        check("t4_third", 32'(req_ready), 32'b0010);

        // Early release after two beats from requester 1.
        apply_reset();
        req_valid = 4'b0110;
        wait_grant("t5");
        check("t5_grant1", 32'(req_ready), 32'b0010);
        step();
        step(); req_valid = 4'b0100; #1;
        step(); #1;
        check("t5_bubble", 32'(grant_active), 0);
        step(); #1;
        check("t5_grant2", 32'(grant_active), 1);
        check("t5_ready2", 32'(req_ready), 32'b0100);
        for (int n = 0; n < 8; n++) step();

        // Asynchronous reset mid-burst.
        req_valid = 4'b1111;
        wait_grant("t6");
        step();
        step();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_data", 32'(out_data), 0);
        check("t6_async_src", 32'(out_src), 0);
        check("t6_async_grant", 32'(grant_active), 0);
        req_valid = 4'b1010;
        step();
        rst_n = 1'b1;
        wait_grant("t6");
        check("t6_first_after_rst", 32'(req_ready), 32'b0010);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom_range(9) < 6);
                d[i] = WIDTH'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
